// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'hACD51302;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h51C1CA47;

endpackage

// File: rtl/soc_system_sysid_timeout.sv
// Per-transaction watchdog: counts cycles from the start of a read request
// and flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module soc_system_sysid_timeout
  import soc_system_sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  // Next count: clear wins, otherwise count up and saturate at the last value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 =
// build timestamp), compares both words against expected values and reports
// the outcome on sticky status flags.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start (or the one-shot auto start after reset)
// REQ_ID   | avm_read held on word 0 until accepted
// WAIT_ID  | word 0 accepted, waiting for readdatavalid
// REQ_TS   | avm_read held on word 1 until accepted
// WAIT_TS  | word 1 accepted, waiting for readdatavalid
// CHECK    | one cycle: compare captured words, set result flags
// DONE     | result held, done=1, waiting for the next start
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  // Wide enough to hold 0..MAX_RETRIES, and at least one bit when retries are off.
  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);

  sysid_state_e  state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          auto_q, auto_d;
  logic          id_ok_q, id_ok_d;
  logic          id_mis_q, id_mis_d;
  logic          ts_mis_q, ts_mis_d;
  logic          tmo_err_q, tmo_err_d;
  logic [31:0]   cap_id_q, cap_id_d;
  logic [31:0]   cap_ts_q, cap_ts_d;

  logic          in_req;
  logic          in_wait;
  logic          accept;
  logic          can_retry;
  logic          tmo_clear;
  logic          tmo_expired;
  logic          tmo_fire;
  sysid_state_e  retry_target;

  soc_system_sysid_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmo_clear),
    .enable (in_req || in_wait),
    .expired(tmo_expired)
  );

  assign in_req    = (state_q == ST_REQ_ID) || (state_q == ST_REQ_TS);
  assign in_wait   = (state_q == ST_WAIT_ID) || (state_q == ST_WAIT_TS);
  // The request is withdrawn in the expiry cycle so a retry always shows a
  // fresh rising edge of avm_read to the interconnect.
  assign avm_read  = in_req && !tmo_expired;
  assign avm_address = (state_q == ST_REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign accept    = avm_read && !avm_waitrequest;
  assign can_retry = (32'(retry_q) < MAX_RETRIES);

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign id_ok       = id_ok_q;
  assign id_mismatch = id_mis_q;
  assign ts_mismatch = ts_mis_q;
  assign timeout_err = tmo_err_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;

  // Sequencer: next state, captures, retry bookkeeping and result flags.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    auto_d       = 1'b0;
    id_ok_d      = id_ok_q;
    id_mis_d     = id_mis_q;
    ts_mis_d     = ts_mis_q;
    tmo_err_d    = tmo_err_q;
    cap_id_d     = cap_id_q;
    cap_ts_d     = cap_ts_q;
    tmo_clear    = 1'b0;
    tmo_fire     = 1'b0;
    retry_target = ST_REQ_ID;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start || auto_q) begin
          state_d   = ST_REQ_ID;
          retry_d   = '0;
          id_ok_d   = 1'b0;
          id_mis_d  = 1'b0;
          ts_mis_d  = 1'b0;
          tmo_err_d = 1'b0;
          tmo_clear = 1'b1;
        end
      end
      ST_REQ_ID: begin
        if (tmo_expired) begin
          tmo_fire     = 1'b1;
          retry_target = ST_REQ_ID;
        end else if (accept) begin
          if (avm_readdatavalid) begin
            cap_id_d  = avm_readdata;
            state_d   = ST_REQ_TS;
            tmo_clear = 1'b1;
          end else begin
            state_d = ST_WAIT_ID;
          end
        end
      end
      ST_WAIT_ID: begin
        if (avm_readdatavalid) begin
          cap_id_d  = avm_readdata;
          state_d   = ST_REQ_TS;
          tmo_clear = 1'b1;
        end else if (tmo_expired) begin
          tmo_fire     = 1'b1;
          retry_target = ST_REQ_ID;
        end
      end
      ST_REQ_TS: begin
        if (tmo_expired) begin
          tmo_fire     = 1'b1;
          retry_target = ST_REQ_TS;
        end else if (accept) begin
          if (avm_readdatavalid) begin
            cap_ts_d = avm_readdata;
            state_d  = ST_CHECK;
          end else begin
            state_d = ST_WAIT_TS;
          end
        end
      end
      ST_WAIT_TS: begin
        if (avm_readdatavalid) begin
          cap_ts_d = avm_readdata;
          state_d  = ST_CHECK;
        end else if (tmo_expired) begin
          tmo_fire     = 1'b1;
          retry_target = ST_REQ_TS;
        end
      end
      ST_CHECK: begin
        id_mis_d = (cap_id_q != EXPECTED_ID);
        ts_mis_d = (cap_ts_q != EXPECTED_TS);
        id_ok_d  = (cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TS);
        state_d  = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The retry budget is shared by both words of one check.
    if (tmo_fire) begin
      tmo_clear = 1'b1;
      if (can_retry) begin
        retry_d = retry_q + RW'(1);
        state_d = retry_target;
      end else begin
        tmo_err_d = 1'b1;
        id_ok_d   = 1'b0;
        state_d   = ST_DONE;
      end
    end
  end

  // State and status registers; auto_q arms the one-shot post-reset start.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      auto_q    <= AUTO_START;
      id_ok_q   <= 1'b0;
      id_mis_q  <= 1'b0;
      ts_mis_q  <= 1'b0;
      tmo_err_q <= 1'b0;
      cap_id_q  <= '0;
      cap_ts_q  <= '0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      auto_q    <= auto_d;
      id_ok_q   <= id_ok_d;
      id_mis_q  <= id_mis_d;
      ts_mis_q  <= ts_mis_d;
      tmo_err_q <= tmo_err_d;
      cap_id_q  <= cap_id_d;
      cap_ts_q  <= cap_ts_d;
    end
  end

endmodule
